// File: rtl/flt2int_pkg.sv
// rtl/flt2int_pkg.sv - shared types and constants for the float-to-integer sequencer
package flt2int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_CVT,
        ST_WAIT,
        ST_WR_HI,
        ST_WR_LO,
        ST_DONE
    } ctrl_state_t;

    localparam logic [7:0]  FLT_SRC_ADDR  = 8'd4;
    localparam logic [7:0]  INT_DST_ADDR  = 8'd6;
    localparam logic [15:0] CVT_ABORT_VAL = 16'h0000;

endpackage

// File: rtl/flt2int_ctrl.sv
// rtl/flt2int_ctrl.sv - float-to-integer sequencer (FLT2INT_BATCH_EN enables multi-item batches)
module flt2int_ctrl
    import flt2int_pkg::*;
#(
    parameter logic [7:0] SRC_BASE = FLT_SRC_ADDR,
    parameter logic [7:0] DST_BASE = INT_DST_ADDR,
    parameter logic [7:0] TIMEOUT  = 8'd255,
    parameter int         N_ITEMS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [7:0]  dm_addr,
    output logic [7:0]  dm_in,
    input  logic [7:0]  dm_out,
    output logic        ReadMem,
    output logic        WriteMem,
    output logic [15:0] flt_op,
    output logic        cvt_go,
    input  logic        cvt_valid,
    input  logic [15:0] int_res,
    output logic [7:0]  cycles
);

    ctrl_state_t state;
    logic        start_q;
    logic        start_ev;
    logic [7:0]  wait_cnt;
    logic [15:0] res;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;

    // Falling edge of the bench request; only honoured from IDLE below.
    assign start_ev = start_q && !start;

`ifdef FLT2INT_BATCH_EN
    logic [7:0] item_idx;
    logic       last_item;

    // Item i lives at a 4-byte stride from each base; arithmetic wraps at 256.
    assign src_addr  = SRC_BASE + {item_idx[5:0], 2'b00};
    assign dst_addr  = DST_BASE + {item_idx[5:0], 2'b00};
    assign last_item = (item_idx == 8'(N_ITEMS - 1));
`else
    logic [31:0] unused_n_items;

    assign src_addr       = SRC_BASE;
    assign dst_addr       = DST_BASE;
    assign unused_n_items = N_ITEMS;
`endif

    // Sequencer: every output is registered and loaded on the edge entering the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            dm_addr  <= 8'd0;
            dm_in    <= 8'd0;
            ReadMem  <= 1'b0;
            WriteMem <= 1'b0;
            flt_op   <= 16'd0;
            cvt_go   <= 1'b0;
            cycles   <= 8'd0;
            wait_cnt <= 8'd0;
            res      <= 16'd0;
`ifdef FLT2INT_BATCH_EN
            item_idx <= 8'd0;
`endif
        end else begin
            start_q  <= start;
            done     <= 1'b0;
            cvt_go   <= 1'b0;
            ReadMem  <= 1'b0;
            WriteMem <= 1'b0;
            dm_addr  <= 8'd0;
            dm_in    <= 8'd0;

            if (busy && cycles != 8'hFF) begin
                cycles <= cycles + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ev) begin
                        err     <= 1'b0;
                        cycles  <= 8'd0;
                        busy    <= 1'b1;
                        dm_addr <= SRC_BASE;
                        ReadMem <= 1'b1;
                        state   <= ST_RD_LO;
`ifdef FLT2INT_BATCH_EN
                        item_idx <= 8'd0;
`endif
                    end
                end
                ST_RD_LO: begin
                    flt_op[7:0] <= dm_out;
                    dm_addr     <= src_addr + 8'd1;
                    ReadMem     <= 1'b1;
                    state       <= ST_RD_HI;
                end
                ST_RD_HI: begin
                    flt_op[15:8] <= dm_out;
                    cvt_go       <= 1'b1;
                    state        <= ST_CVT;
                end
                ST_CVT: begin
                    wait_cnt <= 8'd0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A valid on the final allowed cycle still beats the timeout.
                    if (cvt_valid) begin
                        res      <= int_res;
                        dm_addr  <= dst_addr + 8'd1;
                        dm_in    <= int_res[15:8];
                        WriteMem <= 1'b1;
                        state    <= ST_WR_HI;
                    end else if (wait_cnt == TIMEOUT - 8'd1) begin
                        err      <= 1'b1;
                        res      <= CVT_ABORT_VAL;
                        dm_addr  <= dst_addr + 8'd1;
                        dm_in    <= CVT_ABORT_VAL[15:8];
                        WriteMem <= 1'b1;
                        state    <= ST_WR_HI;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WR_HI: begin
                    dm_addr  <= dst_addr;
                    dm_in    <= res[7:0];
                    WriteMem <= 1'b1;
                    state    <= ST_WR_LO;
                end
                ST_WR_LO: begin
`ifdef FLT2INT_BATCH_EN
                    if (last_item) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        item_idx <= item_idx + 8'd1;
                        dm_addr  <= src_addr + 8'd4;
                        ReadMem  <= 1'b1;
                        state    <= ST_RD_LO;
                    end
`else
                    done  <= 1'b1;
                    state <= ST_DONE;
`endif
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flt2int_ctrl.sv
// tb/tb_flt2int_ctrl.sv - directed self-checking bench for flt2int_ctrl
module tb_flt2int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        busy;
    logic        err;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_in;
    logic [7:0]  dm_out;
    logic        ReadMem;
    logic        WriteMem;
    logic [15:0] flt_op;
    logic        cvt_go;
    logic        cvt_valid;
    logic [15:0] int_res;
    logic [7:0]  cycles;

    logic [7:0]  mem [256];
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;

    int total = 0;
    int bad   = 0;

    int          done_idx;
    int          n_done;
    logic [15:0] op_at_go;

    always #5 clk = ~clk;

    flt2int_ctrl #(.N_ITEMS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .dm_addr   (dm_addr),
        .dm_in     (dm_in),
        .dm_out    (dm_out),
        .ReadMem   (ReadMem),
        .WriteMem  (WriteMem),
        .flt_op    (flt_op),
        .cvt_go    (cvt_go),
        .cvt_valid (cvt_valid),
        .int_res   (int_res),
        .cycles    (cycles)
    );

    // Byte-wide data memory: combinational read, write on the rising edge.
    assign dm_out = mem[dm_addr];

    always @(posedge clk) begin
        if (WriteMem) mem[dm_addr] <= dm_in;
        else if (pl_we) mem[pl_addr] <= pl_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // One request; called right after a negedge. Index i counts negedges after start falls.
    task automatic run_op(input int k, input logic [15:0] val, input bit glitch, input int extra_at,
                          output int d_idx, output int d_cnt, output logic [15:0] op_go);
        int go_idx = -1;
        int n_go   = 0;
        d_idx = -1;
        d_cnt = 0;
        op_go = 16'hxxxx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            cvt_valid = 1'b0;
            int_res   = 16'hDEAD;
            if (done) begin
                d_cnt++;
                if (d_idx < 0) d_idx = i;
            end
            if (cvt_go) begin
                go_idx = i;
                n_go++;
                op_go = flt_op;
                if (glitch) cvt_valid = 1'b1;
            end
            if (k > 0 && go_idx > 0 && i == go_idx + k) begin
                cvt_valid = 1'b1;
                int_res   = val + 16'(n_go - 1);
            end
            start = (extra_at > 0 && i == extra_at);
            if (d_idx > 0 && i >= d_idx + 4) break;
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cvt_valid = 1'b0;
        int_res   = 16'd0;
        pl_we     = 1'b0;
        pl_addr   = 8'd0;
        pl_data   = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_ctl", {26'd0, done, busy, err, ReadMem, WriteMem, cvt_go}, 32'd0);
        check("reset_bus", {8'd0, dm_addr, dm_in, cycles}, 32'd0);
        check("reset_op", {16'd0, flt_op}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef FLT2INT_BATCH_EN
        poke(8'd4, 8'h00); poke(8'd5, 8'h3C);
        poke(8'd8, 8'h00); poke(8'd9, 8'h40);
        poke(8'd6, 8'hAA); poke(8'd7, 8'hAA);
        poke(8'd10, 8'hAA); poke(8'd11, 8'hAA);
        run_op(1, 16'h0001, 1'b0, 0, done_idx, n_done, op_at_go);
        check("batch_done_at", done_idx, 13);
        check("batch_ndone", n_done, 1);
        check("batch_op2", op_at_go, 16'h4000);
        check("batch_m6", mem[6], 8'h01);
        check("batch_m7", mem[7], 8'h00);
        check("batch_m10", mem[10], 8'h02);
        check("batch_m11", mem[11], 8'h00);
        check("batch_cycles", cycles, 8'd13);
        check("batch_err", err, 1'b0);
`else
        // 1.0 in, datapath answers one cycle after launch
        poke(8'd4, 8'h00); poke(8'd5, 8'h3C);
        poke(8'd6, 8'hAA); poke(8'd7, 8'hAA);
        run_op(1, 16'h0001, 1'b0, 0, done_idx, n_done, op_at_go);
        check("t1_done_at", done_idx, 7);
        check("t1_ndone", n_done, 1);
        check("t1_op", op_at_go, 16'h3C00);
        check("t1_m6", mem[6], 8'h01);
        check("t1_m7", mem[7], 8'h00);
        check("t1_err", err, 1'b0);
        check("t1_cycles", cycles, 8'd7);
        check("t1_busy", busy, 1'b0);

        // valid glitch during CVT is ignored; real result 3 cycles after launch
        poke(8'd5, 8'hC1);
        run_op(3, 16'hFFFE, 1'b1, 0, done_idx, n_done, op_at_go);
        check("t2_done_at", done_idx, 9);
        check("t2_op", op_at_go, 16'hC100);
        check("t2_m6", mem[6], 8'hFE);
        check("t2_m7", mem[7], 8'hFF);
        check("t2_cycles", cycles, 8'd9);

        // second start pulse while busy is ignored
        run_op(1, 16'h0042, 1'b0, 3, done_idx, n_done, op_at_go);
        check("t3_ndone", n_done, 1);
        check("t3_done_at", done_idx, 7);
        check("t3_cycles", cycles, 8'd7);
        check("t3_m6", mem[6], 8'h42);

        // datapath never answers: timeout after 255 WAIT cycles
        poke(8'd6, 8'hAA); poke(8'd7, 8'hAA);
        run_op(0, 16'h0000, 1'b0, 0, done_idx, n_done, op_at_go);
        check("t4_done_at", done_idx, 261);
        check("t4_ndone", n_done, 1);
        check("t4_err", err, 1'b1);
        check("t4_m6", mem[6], 8'h00);
        check("t4_m7", mem[7], 8'h00);
        check("t4_cycles", cycles, 8'hFF);

        // valid on the last allowed WAIT cycle wins; err cleared by the new start
        run_op(255, 16'h1234, 1'b0, 0, done_idx, n_done, op_at_go);
        check("t5_done_at", done_idx, 261);
        check("t5_err", err, 1'b0);
        check("t5_m6", mem[6], 8'h34);
        check("t5_m7", mem[7], 8'h12);

        // reset while waiting on the datapath
        poke(8'd6, 8'hAA); poke(8'd7, 8'hAA);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy_pre", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_ctl", {26'd0, done, busy, err, ReadMem, WriteMem, cvt_go}, 32'd0);
        check("t6_rst_bus", {8'd0, dm_addr, dm_in, cycles}, 32'd0);
        check("t6_rst_op", {16'd0, flt_op}, 32'd0);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t6_ndone", n_done, 0);
        check("t6_m6", mem[6], 8'hAA);
        check("t6_m7", mem[7], 8'hAA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flt2int_ctrl.md
# flt2int_ctrl

Sequencer for the float-to-integer program. Detects the test bench's start request and fetches the 16-bit half-precision operand from the shared byte-wide data memory. It launches and waits on the conversion datapath, writes the 16-bit integer result back to memory, and returns a one-cycle `done` acknowledge. It owns the data memory port for the whole operation and sits between the bench handshake, `data_mem`, and the conversion datapath.

## Interface
- `SRC_BASE`, default 8'd4: byte address of the operand low byte; the high byte is at +1.
- `DST_BASE`, default 8'd6: byte address of the result low byte; the high byte is at +1.
- `TIMEOUT`, default 8'd255: maximum number of cycles spent in WAIT before aborting.
- `N_ITEMS`, default 4: number of conversions per request. Used only with `FLT2INT_BATCH_EN`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  bench request. The operation begins on its falling edge.
- `done`  out  1  one-cycle acknowledge.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky timeout flag; cleared at the next accepted start.
- `dm_addr`  out  8  data memory address.
- `dm_in`  out  8  write data to memory.
- `dm_out`  in  8  memory read data. Read is combinational from `dm_addr`.
- `ReadMem`  out  1  memory read enable.
- `WriteMem`  out  1  memory write enable; the write occurs at the rising edge.
- `flt_op`  out  16  operand to the datapath, held stable from CVT until the datapath returns valid.
- `cvt_go`  out  1  one-cycle datapath launch.
- `cvt_valid`  in  1  datapath result valid. Sampled only in WAIT.
- `int_res`  in  16  datapath result, captured when `cvt_valid`=1.
- `cycles`  out  8  cycle counter: cleared at accepted start, increments while `busy`, saturates at 8'hFF.

## Operation
- Start detection: a registered copy `start_q` is kept. The start event is `start_q && !start`, and it is accepted only in IDLE; outside IDLE it is ignored.
- States: IDLE, RD_LO, RD_HI, CVT, WAIT, WR_HI, WR_LO, DONE.
- IDLE: on an accepted start, clear `err` and `cycles`, set the item index to 0, and go to RD_LO.
- RD_LO: `dm_addr`=src, `ReadMem`=1; capture `dm_out` into `flt_op[7:0]`. Next state RD_HI.
- RD_HI: `dm_addr`=src+1; capture into `flt_op[15:8]`. Next state CVT.
- CVT: `cvt_go`=1 for exactly this cycle. Next state WAIT; clear the wait counter.
- WAIT: if `cvt_valid`=1, capture `int_res` and go to WR_HI. Otherwise increment the wait counter. When the counter reaches `TIMEOUT`, set `err`=1, load the result register with 16'h0000, and go to WR_HI.
- WR_HI: `dm_addr`=dst+1, `dm_in`=res[15:8], `WriteMem`=1. Next state WR_LO.
- WR_LO: `dm_addr`=dst, `dm_in`=res[7:0], `WriteMem`=1. Next state is DONE, or RD_LO for the next item (batch mode only).
- DONE: `done`=1 for one cycle, then IDLE.
- Outside the listed states, `ReadMem`, `WriteMem` and `cvt_go` are 0, and `dm_addr`/`dm_in` are 0.
- Address arithmetic is 8-bit and wraps modulo 256.
- The block performs no rounding or saturation; the datapath alone determines the result value.

## Timing
- Reset values: `done`, `busy`, `err`, `WriteMem`, `ReadMem`, `cvt_go` = 0. `dm_addr`, `dm_in`, `flt_op`, `cycles` = 0. State = IDLE, `start_q` = 0.
- Reset mid-operation: the block returns to IDLE on the next edge. No further memory write occurs, and `done` is not issued.
- Latency, single item: edge E0 detects the start event. `cvt_go` is high in the cycle after E2. With `cvt_valid` seen k cycles after `cvt_go` (k≥1), `done` is high in the cycle after edge E(5+k).
- `cvt_valid` asserted during CVT is ignored.
- `cvt_valid` and the timeout occurring on the same edge: valid wins, and `err` stays 0.
- `start` rising again while busy has no effect. A falling edge of `start` is honoured only if it is observed in IDLE.

## Configuration
- `FLT2INT_BATCH_EN` defined: each request processes `N_ITEMS` items.
  - Item i reads from SRC_BASE+4i and writes to DST_BASE+4i.
  - WR_LO goes to RD_LO until the last item, then goes to DONE.
  - A single `done` pulse is issued for the whole batch.
  - `err` is set if any item times out.
- Macro undefined: exactly one item at SRC_BASE/DST_BASE, and the item index logic is not compiled.

## Structure
- `flt2int_pkg` holds:
  - the state enum `ctrl_state_t`;
  - default address constants `FLT_SRC_ADDR`=4 and `INT_DST_ADDR`=6;
  - the result sentinel `CVT_ABORT_VAL`=16'h0000.
- No sub-module; start edge detection is inline. The conversion datapath is a separate peer module, not instantiated here.

## Test plan
- mem[4]=8'h00, mem[5]=8'h3C (1.0); datapath returns 16'h0001 one cycle after `cvt_go` → mem[6]=8'h01, mem[7]=8'h00, and `done` high 7 cycles after the start edge.
- Datapath never asserts `cvt_valid` → after 255 WAIT cycles, `err`=1, mem[6..7]=8'h00, `done` pulses once.
- Reset asserted in WAIT → IDLE on the next edge, no writes to mem[6..7], `done` stays 0, all outputs at reset values.
- Second `start` pulse while busy → ignored; exactly one `done`, and `cycles` is not cleared.
- `cvt_valid` held high during CVT and then dropped, followed by a valid pulse 3 cycles later → the later value is captured; the CVT-cycle value is never written.
- With `FLT2INT_BATCH_EN` and `N_ITEMS`=2 → items read from 4/5 and 8/9 and written to 6/7 and 10/11, with a single `done`.
